// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Accepts one op per cycle while idle. ALU ops write back the next cycle.
// Legal loads and stores run a req/gnt/rvalid transaction to data memory.
// Illegal or misaligned ops raise a one-cycle mem_fault pulse.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a transaction
// that sits in REQ/WAIT for TIMEOUT_CYCLES cycles is abandoned with a fault.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_mem_address,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mem_fault_q, mem_fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [35:0] lanes_s;

    // Opcode is legal for its direction and the address is aligned to its size.
    function automatic logic op_legal(input logic ld, input logic st,
                                      input logic [2:0] f3, input logic [1:0] a);
        logic code_ok;
        logic align_ok;
        code_ok = 1'b0;
        if (ld && !st) begin
            code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                      (f3 == 3'd4) || (f3 == 3'd5);
        end else if (st && !ld) begin
            code_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        end else begin
            code_ok = 1'b0;
        end
        case (f3[1:0])
            2'b01:   align_ok = (a[0] == 1'b0);
            2'b10:   align_ok = (a == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return code_ok && align_ok;
    endfunction

    // Store lane placement: returns {wstrb, wdata} with the data replicated.
    function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [35:0] r;
        case (f3)
            3'd0:    r = {4'b0001 << a, {4{d[7:0]}}};
            3'd1:    r = {(a[1] ? 4'b1100 : 4'b0011), {2{d[15:0]}}};
            3'd2:    r = {4'b1111, d};
            default: r = 36'd0;
        endcase
        return r;
    endfunction

    // Load lane extraction with sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [31:0] byte_s;
        logic [31:0] half_s;
        logic [31:0] r;
        byte_s = rdata >> {a, 3'b000};
        half_s = rdata >> {a[1], 4'b0000};
        case (f3)
            3'd0:    r = {{24{byte_s[7]}}, byte_s[7:0]};
            3'd4:    r = {24'd0, byte_s[7:0]};
            3'd1:    r = {{16{half_s[15]}}, half_s[15:0]};
            3'd5:    r = {16'd0, half_s[15:0]};
            3'd2:    r = rdata;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_s;

    // Cycle counter: zero while idle, counts every cycle in REQ/WAIT, saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = 16'd0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_s = (cnt_q >= TIMEOUT_LAST);
`else
    // A zero timeout has no meaning; this block only ties the parameter's legal range.
    if (TIMEOUT_CYCLES == 32'd0) begin : g_timeout_zero
    end
`endif

    assign lanes_s = store_lanes(ex_funct3, ex_mem_address[1:0], ex_store_data);

    // Next-state, latched transaction fields and writeback/fault packet.
    always_comb begin
        state_d      = state_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        mem_fault_d  = 1'b0;
        fault_addr_d = fault_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && !ex_is_load && !ex_is_store) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = ex_reg_write && (ex_rd != 5'd0);
                    wb_rd_d    = ex_rd;
                    wb_data_d  = ex_result;
                end else if (ex_valid && !op_legal(ex_is_load, ex_is_store, ex_funct3,
                                                   ex_mem_address[1:0])) begin
                    mem_fault_d  = 1'b1;
                    fault_addr_d = ex_mem_address;
                end else if (ex_valid) begin
                    state_d     = ST_REQ;
                    is_load_d   = ex_is_load;
                    funct3_d    = ex_funct3;
                    addr_d      = ex_mem_address;
                    wdata_d     = ex_is_load ? 32'd0 : lanes_s[31:0];
                    wstrb_d     = ex_is_load ? 4'd0 : lanes_s[35:32];
                    rd_d        = ex_rd;
                    reg_write_d = ex_reg_write;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt && is_load_q) begin
                    state_d = ST_WAIT;
                end else if (dmem_gnt) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_rd_d    = rd_q;
                    wb_data_d  = 32'd0;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_s) begin
                    state_d      = ST_IDLE;
                    mem_fault_d  = 1'b1;
                    fault_addr_d = addr_q;
                end
`endif
                else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = reg_write_q && (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_extract(funct3_q, addr_q[1:0], dmem_rdata);
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_s) begin
                    state_d      = ST_IDLE;
                    mem_fault_d  = 1'b1;
                    fault_addr_d = addr_q;
                end
`endif
                else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, transaction and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            mem_fault_q  <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            mem_fault_q  <= mem_fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Memory bus is driven straight from the state and latched fields.
    assign ex_ready   = (state_q == ST_IDLE);
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = dmem_req && !is_load_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign mem_fault  = mem_fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a byte-level reference
// model and a per-cycle compare of the writeback and fault outputs.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result, ex_mem_address, ex_store_data;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_we, mem_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fault_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;

    typedef struct {
        bit          wb;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chk_data;
        bit          fault;
        logic [31:0] faddr;
    } exp_t;
    exp_t exp_q [int];

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_result(ex_result),
        .ex_mem_address(ex_mem_address), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_fault(mem_fault), .fault_addr(fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr);
        bit code_ok;
        if (ld && !st)      code_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else if (st && !ld) code_ok = (f3 inside {3'd0, 3'd1, 3'd2});
        else                code_ok = 1'b0;
        return code_ok && ((addr % size_of(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] s;
        int a = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) s[i] = (i >= a) && (i < a + size_of(f3));
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [7:0]  bytes [4];
        logic [31:0] v;
        int a = int'(addr[1:0]);
        int sz = size_of(f3);
        bit sgn;
        for (int i = 0; i < 4; i++) bytes[i] = rdata[8*i +: 8];
        v = 32'd0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = bytes[a + k];
        sgn = (f3[2] == 1'b0) && (sz < 4) && v[8*sz - 1];
        for (int k = sz; k < 4; k++) v[8*k +: 8] = sgn ? 8'hFF : 8'h00;
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = '{wb: 1'b0, we: 1'b0, rd: 5'd0, data: 32'd0, chk_data: 1'b0,
                  fault: 1'b0, faddr: 32'd0};
            if (exp_q.exists(cyc)) e = exp_q[cyc];
            chk("wb_valid", 32'(wb_valid), 32'(e.wb));
            chk("mem_fault", 32'(mem_fault), 32'(e.fault));
            if (e.wb) begin
                chk("wb_we", 32'(wb_we), 32'(e.we));
                if (e.chk_data) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (e.fault) chk("fault_addr", fault_addr, e.faddr);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic idle_inputs();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
        ex_result = 32'd0; ex_mem_address = 32'd0; ex_store_data = 32'd0;
        ex_rd = 5'd0; ex_reg_write = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input bit we);
        exp_t e;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_result = res; ex_rd = rd; ex_reg_write = we;
        chk("alu_ready", 32'(ex_ready), 32'd1);
        e = '{wb: 1'b1, we: (we && rd != 5'd0), rd: rd, data: res, chk_data: 1'b1,
              fault: 1'b0, faddr: 32'd0};
        exp_q[cyc + 1] = e;
        tick();
        ex_valid = 1'b0;
    endtask

    // Issues one memory op; returns in the cycle its writeback or fault is visible.
    task automatic mem_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input bit rwe, input int gnt_dly,
                          input logic [31:0] rdata, input int rv_dly);
        exp_t e;
        bit legal = m_legal(ld, st, f3, addr);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_mem_address = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = rwe;
        ex_result = 32'h5A5A5A5A;
        chk("mem_accept_ready", 32'(ex_ready), 32'd1);
        if (!legal) begin
            e = '{wb: 1'b0, we: 1'b0, rd: 5'd0, data: 32'd0, chk_data: 1'b0,
                  fault: 1'b1, faddr: addr};
            exp_q[cyc + 1] = e;
            tick();
            ex_valid = 1'b0;
            chk("fault_no_req", 32'(dmem_req), 32'd0);
            chk("fault_ready", 32'(ex_ready), 32'd1);
            return;
        end
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            chk("req_high", 32'(dmem_req), 32'd1);
            chk("req_ready_low", 32'(ex_ready), 32'd0);
            chk("req_we", 32'(dmem_we), 32'(st));
            chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            if (st) begin
                chk("req_wdata", dmem_wdata, m_wdata(f3, sdata));
                chk("req_wstrb", 32'(dmem_wstrb), 32'(m_wstrb(f3, addr)));
            end
            seen_addr = dmem_addr; seen_wdata = dmem_wdata; seen_wstrb = dmem_wstrb;
            dmem_gnt = (i == gnt_dly);
            if (i == gnt_dly && st) begin
                e = '{wb: 1'b1, we: 1'b0, rd: rd, data: 32'd0, chk_data: 1'b0,
                      fault: 1'b0, faddr: 32'd0};
                exp_q[cyc + 1] = e;
            end
            tick();
        end
        dmem_gnt = 1'b0;
        if (ld) begin
            for (int i = 0; i <= rv_dly; i++) begin
                chk("wait_req_low", 32'(dmem_req), 32'd0);
                chk("wait_ready_low", 32'(ex_ready), 32'd0);
                dmem_rvalid = (i == rv_dly);
                dmem_rdata = (i == rv_dly) ? rdata : 32'hDEADBEEF;
                if (i == rv_dly) begin
                    e = '{wb: 1'b1, we: (rwe && rd != 5'd0), rd: rd,
                          data: m_load(f3, addr, rdata), chk_data: 1'b1,
                          fault: 1'b0, faddr: 32'd0};
                    exp_q[cyc + 1] = e;
                end
                tick();
            end
            dmem_rvalid = 1'b0;
        end
        chk("done_ready", 32'(ex_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault", 32'(mem_fault), 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ALU ops back to back
        alu_op(32'h12345678, 5'd5, 1'b1);
        chk("alu_lit_data", wb_data, 32'h12345678);
        chk("alu_lit_we", 32'(wb_we), 32'd1);
        alu_op(32'hCAFEBABE, 5'd0, 1'b1);
        alu_op(32'h00000001, 5'd9, 1'b0);
        alu_op(32'hFFFFFFFF, 5'd31, 1'b1);
        tick();

        // Stores
        mem_op(1'b0, 1'b1, 3'd0, 32'h00000103, 32'h000000AB, 5'd1, 1'b0, 2, 32'd0, 0);
        chk("sb_lit_addr", seen_addr, 32'h00000100);
        chk("sb_lit_wstrb", 32'(seen_wstrb), 32'h8);
        chk("sb_lit_wdata", seen_wdata, 32'hABABABAB);
        mem_op(1'b0, 1'b1, 3'd1, 32'h00000102, 32'h1234BEEF, 5'd2, 1'b1, 0, 32'd0, 0);
        chk("sh_lit_wdata", seen_wdata, 32'hBEEFBEEF);
        chk("sh_lit_wstrb", 32'(seen_wstrb), 32'hC);
        mem_op(1'b0, 1'b1, 3'd2, 32'h00000104, 32'h01020304, 5'd3, 1'b1, 1, 32'd0, 0);

        // Loads
        mem_op(1'b1, 1'b0, 3'd0, 32'h00000201, 32'd0, 5'd7, 1'b1, 0, 32'h0000F000, 0);
        chk("lb_lit", wb_data, 32'hFFFFFFF0);
        mem_op(1'b1, 1'b0, 3'd4, 32'h00000201, 32'd0, 5'd8, 1'b1, 1, 32'h0000F000, 2);
        chk("lbu_lit", wb_data, 32'h000000F0);
        mem_op(1'b1, 1'b0, 3'd1, 32'h00000202, 32'd0, 5'd9, 1'b1, 0, 32'h80010000, 1);
        chk("lh_lit", wb_data, 32'hFFFF8001);
        mem_op(1'b1, 1'b0, 3'd5, 32'h00000202, 32'd0, 5'd10, 1'b1, 0, 32'h80010000, 0);
        chk("lhu_lit", wb_data, 32'h00008001);
        mem_op(1'b1, 1'b0, 3'd2, 32'h00000300, 32'd0, 5'd0, 1'b1, 0, 32'hCAFEF00D, 0);
        chk("lw_rd0_we", 32'(wb_we), 32'd0);

        // Illegal / misaligned
        mem_op(1'b1, 1'b0, 3'd2, 32'h00000302, 32'd0, 5'd4, 1'b1, 0, 32'd0, 0);
        chk("lw_mis_lit_fault", 32'(mem_fault), 32'd1);
        chk("lw_mis_lit_addr", fault_addr, 32'h00000302);
        mem_op(1'b1, 1'b0, 3'd1, 32'h00000203, 32'd0, 5'd4, 1'b1, 0, 32'd0, 0);
        mem_op(1'b0, 1'b1, 3'd4, 32'h00000400, 32'd0, 5'd4, 1'b1, 0, 32'd0, 0);
        mem_op(1'b1, 1'b0, 3'd3, 32'h00000400, 32'd0, 5'd4, 1'b1, 0, 32'd0, 0);
        mem_op(1'b1, 1'b1, 3'd0, 32'h00000404, 32'd0, 5'd4, 1'b1, 0, 32'd0, 0);
        tick();

        // Reset while a load waits for data
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'd2;
        ex_mem_address = 32'h00000600; ex_rd = 5'd6; ex_reg_write = 1'b1;
        tick();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("wait_before_rst", 32'(ex_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_wb", 32'(wb_valid), 32'd0);
        chk("rst_mid_ready", 32'(ex_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
        tick();
        dmem_rvalid = 1'b0;
        chk("stray_rvalid_wb", 32'(wb_valid), 32'd0);

        // Reset while a request is outstanding
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1; ex_funct3 = 3'd2;
        ex_mem_address = 32'h00000700; ex_store_data = 32'h77777777;
        tick();
        ex_valid = 1'b0;
        chk("req_before_rst", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", 32'(dmem_req), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Normal traffic afterwards
        mem_op(1'b1, 1'b0, 3'd2, 32'h00000500, 32'd0, 5'd12, 1'b1, 1, 32'hA5A5_0F0F, 1);
        chk("post_rst_lw", wb_data, 32'hA5A50F0F);
        alu_op(32'h0BADF00D, 5'd13, 1'b1);

`ifdef MEM_TIMEOUT_EN
        // Grant never comes: fault four cycles after REQ entry
        begin
            exp_t e;
            ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'd2;
            ex_mem_address = 32'h00000800; ex_rd = 5'd14; ex_reg_write = 1'b1;
            tick();
            ex_valid = 1'b0;
            e = '{wb: 1'b0, we: 1'b0, rd: 5'd0, data: 32'd0, chk_data: 1'b0,
                  fault: 1'b1, faddr: 32'h00000800};
            exp_q[cyc + 4] = e;
            for (int i = 0; i < 4; i++) begin
                chk("to_req", 32'(dmem_req), 32'd1);
                tick();
            end
            chk("to_req_drop", 32'(dmem_req), 32'd0);
            chk("to_fault_lit", 32'(mem_fault), 32'd1);
            chk("to_ready", 32'(ex_ready), 32'd1);
            tick();
        end
        // Grant in the timeout cycle wins
        mem_op(1'b1, 1'b0, 3'd2, 32'h00000900, 32'd0, 5'd15, 1'b1, 3, 32'h13572468, 0);
        chk("to_gnt_prio", wb_data, 32'h13572468);
`endif

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result, memory address and store data produced by execute.
- Performs byte/half/word loads and stores to data memory over a req/gnt/rvalid handshake, then presents a single-cycle writeback packet to the register file.
- Stalls execute through a ready signal while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT before a timeout fault (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an op
- ex_ready  out  1  stage can accept an op this cycle
- ex_is_load  in  1  op is a load
- ex_is_store  in  1  op is a store
- ex_funct3  in  3  RISC-V width/sign code
- ex_result  in  32  ALU result (non-memory writeback data)
- ex_mem_address  in  32  byte address
- ex_store_data  in  32  store source register value
- ex_rd  in  5  destination register
- ex_reg_write  in  1  op writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  writeback packet valid, one-cycle pulse
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  32  writeback data
- mem_fault  out  1  one-cycle fault pulse
- fault_addr  out  32  faulting byte address

Behaviour:
- Reset: state=IDLE. All outputs 0 except ex_ready=1. Asserting rst_n low mid-transaction drops dmem_req immediately and abandons the transaction; no writeback is produced.
- FSM states: IDLE, REQ, WAIT.
- ex_ready = (state==IDLE). An op is accepted when ex_valid && ex_ready.
- Non-memory op: stays in IDLE. Next cycle: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_we=ex_reg_write. Latency 1, throughput 1 per cycle.
- wb_we is forced to 0 when rd==0.
- Legality check at acceptance:
  - Legal loads: funct3 0,1,2,4,5.
  - Legal stores: funct3 0,1,2.
  - Half accesses require addr[0]==0; word accesses require addr[1:0]==0.
  - Illegal op or misaligned address: next cycle mem_fault=1, fault_addr=address, wb_valid=0, no dmem request, remain in IDLE.
- Legal memory op: IDLE→REQ. All fields are latched.
- REQ:
  - dmem_req=1 with stable addr/we/wdata/wstrb until dmem_gnt is sampled high.
  - Store: on grant, →IDLE; next cycle wb_valid=1, wb_we=0.
  - Load: on grant, →WAIT.
- WAIT:
  - dmem_req=0.
  - On dmem_rvalid: extract the lane; next cycle wb_valid=1, wb_data=extended value, →IDLE.
  - dmem_rvalid outside WAIT is ignored.
  - Minimum load latency from acceptance: 3 cycles (gnt and rvalid each in their first eligible cycle).
- Store lanes:
  - SB: wdata={4{byte}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{half}}, wstrb=0011 if addr[1]==0, else 1100.
  - SW: full word, wstrb=1111.
- Load extract, byte lane selected by addr[1:0]:
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half at addr[1].
  - LHU: zero-extend half at addr[1].
  - LW: whole word.
- ex_is_load && ex_is_store both set: treated as illegal (fault).

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: mem_fault=1, fault_addr=latched address, dmem_req drops, →IDLE, no writeback.
  - A gnt/rvalid arriving in the same cycle as the timeout takes priority, and the transaction completes normally.
- Not defined: no counter; REQ/WAIT wait indefinitely.

Test Plan:
- ALU op, ex_result=0x12345678, rd=5 -> wb_valid next cycle, wb_data=0x12345678, wb_we=1. Back-to-back ops accepted every cycle.
- SB, addr=0x103, data=0x000000AB, gnt after 2 cycles -> dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB held through the stall, ex_ready=0 until IDLE.
- LB, addr=0x201, rdata=0x0000F000 -> wb_data=0xFFFFFFF0. LBU on the same data -> 0x000000F0. LH, addr=0x202, rdata=0x80010000 -> 0xFFFF8001.
- LW, addr=0x302 -> mem_fault pulse, fault_addr=0x302, no dmem_req, no wb_valid.
- Load in WAIT, rst_n pulled low -> dmem_req/wb_valid 0 immediately. Later rvalid is ignored; the next op proceeds normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted -> mem_fault 4 cycles after REQ entry, dmem_req drops.
